// File: rtl/regfile_pkg.sv
// Shared types and constants for the decode-stage register file and bypass network.
// Types are sized at the default configuration; parameterised RTL uses its own widths.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 32;
  localparam int AW_DEF     = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  localparam reg_addr_t ZERO_REG  = '0;
  localparam word_t     ZERO_WORD = '0;

  typedef struct packed {
    logic      we;
    logic      rdy;
    reg_addr_t waddr;
    word_t     wdata;
  } fwd_src_t;

endpackage

// File: rtl/regfile_fwd_sb_fwd_mux.sv
// Per-read-port operand resolution: youngest in-flight stage first, then WB bypass,
// then the architectural value gated by the busy scoreboard.
module fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = AW_DEF,
  parameter int NFWD   = 3
) (
  input  logic [AW-1:0]          addr,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD*AW-1:0]     fwd_waddr,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_waddr,
  input  logic [DATA_W-1:0]      wb_wdata,
  input  logic [DATA_W-1:0]      gpr_data,
  input  logic                   busy,
  output logic [DATA_W-1:0]      data,
  output logic                   hazard
);

  logic              hit;
  logic              hit_rdy;
  logic [DATA_W-1:0] hit_data;

  // First match in index order wins, so an older stage never overrides a younger one.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int unsigned s = 0; s < NFWD; s++) begin
      if (!hit && fwd_we[s] && (fwd_waddr[s*AW +: AW] == addr)) begin
        hit      = 1'b1;
        hit_rdy  = fwd_rdy[s];
        hit_data = fwd_wdata[s*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    data   = '0;
    hazard = 1'b0;
    if (addr != AW'(ZERO_REG)) begin
      if (hit) begin
        data   = hit_data;
        hazard = !hit_rdy;
      end else if (wb_we && (wb_waddr == addr)) begin
        data = wb_wdata;
      end else begin
        data   = gpr_data;
        hazard = busy;
      end
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// Decode-stage GPR file with multi-source forwarding, long-latency busy scoreboard
// and operand stall generation.
module regfile_fwd_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  NREG   = NREG_DEF,
  parameter int  NRD    = 2,
  parameter int  NFWD   = 3,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD-1:0]         rd_en_i,
  input  logic [NRD*AW-1:0]      rd_addr_i,
  output logic [NRD*DATA_W-1:0]  rd_data_o,
  output logic                   stall_o,
  input  logic [NFWD-1:0]        fwd_we_i,
  input  logic [NFWD*AW-1:0]     fwd_waddr_i,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NFWD-1:0]        fwd_rdy_i,
  input  logic                   wb_we_i,
  input  logic [AW-1:0]          wb_waddr_i,
  input  logic [DATA_W-1:0]      wb_wdata_i,
  input  logic                   iss_fire_i,
  input  logic                   iss_long_i,
  input  logic [AW-1:0]          iss_waddr_i,
  input  logic                   sb_clear_i,
  output logic [31:0]            stall_cnt_o
);

  logic [DATA_W-1:0]     gpr [NREG];
  logic [NREG-1:0]       busy;
  logic [NRD-1:0]        hazard;
  logic [NRD*DATA_W-1:0] port_data;
  logic                  stall;
  logic [31:0]           stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_we_i && (wb_waddr_i != AW'(ZERO_REG))) begin
      gpr[wb_waddr_i] <= wb_wdata_i;
    end
  end

  // Later non-blocking assignment wins: issue-set overrides a same-cycle WB clear.
  always_ff @(posedge clk) begin
    if (rst || sb_clear_i) begin
      busy <= '0;
    end else begin
      if (wb_we_i) busy[wb_waddr_i] <= 1'b0;
      if (iss_fire_i && iss_long_i && (iss_waddr_i != AW'(ZERO_REG)))
        busy[iss_waddr_i] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] addr;
    assign addr = rd_addr_i[p*AW +: AW];

    fwd_mux #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NFWD   (NFWD)
    ) u_fwd_mux (
      .addr      (addr),
      .fwd_we    (fwd_we_i),
      .fwd_waddr (fwd_waddr_i),
      .fwd_wdata (fwd_wdata_i),
      .fwd_rdy   (fwd_rdy_i),
      .wb_we     (wb_we_i),
      .wb_waddr  (wb_waddr_i),
      .wb_wdata  (wb_wdata_i),
      .gpr_data  (gpr[addr]),
      .busy      (busy[addr]),
      .data      (port_data[p*DATA_W +: DATA_W]),
      .hazard    (hazard[p])
    );
  end

  always_comb begin
    stall     = !rst && |(rd_en_i & hazard);
    rd_data_o = rst ? '0 : port_data;
    stall_o   = stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;

  iss_during_stall: assert property (@(posedge clk) disable iff (rst) !(iss_fire_i && stall_o));

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Scoreboard bench for regfile_fwd_sb: directed scenarios followed by random traffic
// against a behavioural register-file/scoreboard model.
module tb_regfile_fwd_sb;
  import regfile_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AWD = 5;
  localparam int NRD = 2;
  localparam int NF  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NRD-1:0]     rd_en;
  reg_addr_t          a [NRD];
  logic [NRD*AWD-1:0] rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic               stall;
  logic [31:0]        stall_cnt;
  fwd_src_t           stg [NF];
  logic [NF-1:0]      fwd_we, fwd_rdy;
  logic [NF*AWD-1:0]  fwd_waddr;
  logic [NF*DW-1:0]   fwd_wdata;
  logic               wb_we;
  reg_addr_t          wb_waddr;
  word_t              wb_wdata;
  logic               iss_fire, iss_long;
  reg_addr_t          iss_waddr;
  logic               sb_clear;

  always #5 clk = ~clk;

  always_comb begin
    rd_addr   = '0;
    fwd_we    = '0;
    fwd_rdy   = '0;
    fwd_waddr = '0;
    fwd_wdata = '0;
    for (int p = 0; p < NRD; p++) rd_addr[p*AWD +: AWD] = a[p];
    for (int s = 0; s < NF; s++) begin
      fwd_we[s]              = stg[s].we;
      fwd_rdy[s]             = stg[s].rdy;
      fwd_waddr[s*AWD +: AWD] = stg[s].waddr;
      fwd_wdata[s*DW +: DW]   = stg[s].wdata;
    end
  end

  regfile_fwd_sb #(
    .DATA_W (DW),
    .NREG   (NR),
    .NRD    (NRD),
    .NFWD   (NF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .stall_o     (stall),
    .fwd_we_i    (fwd_we),
    .fwd_waddr_i (fwd_waddr),
    .fwd_wdata_i (fwd_wdata),
    .fwd_rdy_i   (fwd_rdy),
    .wb_we_i     (wb_we),
    .wb_waddr_i  (wb_waddr),
    .wb_wdata_i  (wb_wdata),
    .iss_fire_i  (iss_fire),
    .iss_long_i  (iss_long),
    .iss_waddr_i (iss_waddr),
    .sb_clear_i  (sb_clear),
    .stall_cnt_o (stall_cnt)
  );

  typedef struct {
    word_t       d0, d1;
    bit          hz0, hz1;
    bit          st;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;

  word_t       m_gpr  [NR];
  bit          m_busy [NR];
  logic [31:0] m_cnt   = '0;
  bit          m_stall = 1'b0;

  // Youngest matching stage found by scanning oldest-to-youngest and keeping the last hit.
  function automatic void ref_read(input reg_addr_t ad, output word_t d, output bit hz);
    int y;
    y  = -1;
    d  = '0;
    hz = 1'b0;
    if (ad == 0) return;
    for (int s = NF - 1; s >= 0; s--)
      if (stg[s].we && stg[s].waddr == ad) y = s;
    if (y >= 0) begin
      d  = stg[y].wdata;
      hz = !stg[y].rdy;
    end else if (wb_we && wb_waddr == ad) begin
      d = wb_wdata;
    end else begin
      d  = m_gpr[ad];
      hz = m_busy[ad];
    end
  endfunction

  task automatic commit();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_gpr[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_cnt = '0;
    end else begin
      if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (wb_we && wb_waddr != 0) m_gpr[wb_waddr] = wb_wdata;
      if (sb_clear) begin
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end else begin
        if (wb_we) m_busy[wb_waddr] = 1'b0;
        if (iss_fire && iss_long && iss_waddr != 0) m_busy[iss_waddr] = 1'b1;
      end
    end
  endtask

  task automatic predict();
    exp_t  e;
    word_t d;
    bit    h;
    ref_read(a[0], d, h); e.d0 = d; e.hz0 = h;
    ref_read(a[1], d, h); e.d1 = d; e.hz1 = h;
    e.st = !rst && ((rd_en[0] && e.hz0) || (rd_en[1] && e.hz1));
    if (rst) begin
      e.d0 = '0; e.d1 = '0; e.hz0 = 1'b0; e.hz1 = 1'b0;
    end
    e.cnt   = m_cnt;
    m_stall = e.st;
    q.push_back(e);
    n_vec++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic clear_inputs();
    rst      = 1'b0;
    rd_en    = '0;
    a[0]     = '0;
    a[1]     = '0;
    for (int s = 0; s < NF; s++) stg[s] = '0;
    wb_we    = 1'b0;
    wb_waddr = '0;
    wb_wdata = '0;
    iss_fire = 1'b0;
    iss_long = 1'b0;
    iss_waddr = '0;
    sb_clear = 1'b0;
  endtask

  task automatic rd(input int p, input reg_addr_t ad);
    rd_en[p] = 1'b1;
    a[p]     = ad;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (stall !== e.st) begin
        n_err++;
        $display("FAIL stall vec=%0d got=%b exp=%b", n_vec, stall, e.st);
      end
      if (stall_cnt !== e.cnt) begin
        n_err++;
        $display("FAIL stall_cnt vec=%0d got=%0d exp=%0d", n_vec, stall_cnt, e.cnt);
      end
      if (!e.hz0 && rd_data[31:0] !== e.d0) begin
        n_err++;
        $display("FAIL rd_data0 vec=%0d got=%h exp=%h", n_vec, rd_data[31:0], e.d0);
      end
      if (!e.hz1 && rd_data[63:32] !== e.d1) begin
        n_err++;
        $display("FAIL rd_data1 vec=%0d got=%h exp=%h", n_vec, rd_data[63:32], e.d1);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    next_cycle(); rst = 1'b1; rd(0, 5'd5); rd(1, 5'd5); predict();

    next_cycle(); clear_inputs(); rd(0, 5'd5); rd(1, 5'd5); predict();
    next_cycle(); clear_inputs();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1234; rd(0, 5'd3); predict();
    next_cycle(); clear_inputs(); rd(0, 5'd3); predict();

    next_cycle(); clear_inputs();
    stg[0] = '{we: 1'b1, rdy: 1'b1, waddr: 5'd7, wdata: 32'hAAAA};
    stg[2] = '{we: 1'b1, rdy: 1'b1, waddr: 5'd7, wdata: 32'h5555};
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h5555; rd(1, 5'd7); predict();

    next_cycle(); clear_inputs();
    stg[0] = '{we: 1'b1, rdy: 1'b0, waddr: 5'd9, wdata: 32'h0};
    stg[2] = '{we: 1'b1, rdy: 1'b1, waddr: 5'd9, wdata: 32'h7777};
    rd(0, 5'd9); predict();
    next_cycle(); clear_inputs();
    stg[1] = '{we: 1'b1, rdy: 1'b1, waddr: 5'd9, wdata: 32'h9999};
    rd(0, 5'd9); predict();

    next_cycle(); clear_inputs();
    iss_fire = 1'b1; iss_long = 1'b1; iss_waddr = 5'd4; predict();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); clear_inputs(); rd(0, 5'd4); predict();
    end
    next_cycle(); clear_inputs();
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'hBEEF; rd(0, 5'd4); predict();
    next_cycle(); clear_inputs(); rd(0, 5'd4); predict();

    next_cycle(); clear_inputs();
    iss_fire = 1'b1; iss_long = 1'b1; iss_waddr = 5'd4;
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'hCAFE; predict();
    next_cycle(); clear_inputs(); rd(1, 5'd4); predict();
    next_cycle(); clear_inputs(); sb_clear = 1'b1; predict();
    next_cycle(); clear_inputs(); rd(0, 5'd4); rd(1, 5'd4); predict();
    next_cycle(); clear_inputs();
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF; rd(1, 5'd0); predict();
    next_cycle(); clear_inputs(); rd(0, 5'd0); rd(1, 5'd0); predict();

    for (int i = 0; i < 3000; i++) begin
      next_cycle(); clear_inputs();
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < NRD; p++) begin
        rd_en[p] = 1'($urandom_range(0, 1));
        a[p]     = 5'($urandom_range(0, 7));
      end
      for (int s = 0; s < NF; s++) begin
        stg[s].we    = 1'($urandom_range(0, 1));
        stg[s].rdy   = ($urandom_range(0, 3) != 0);
        stg[s].waddr = 5'($urandom_range(0, 7));
        stg[s].wdata = $urandom;
      end
      wb_we    = 1'($urandom_range(0, 1));
      wb_waddr = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      sb_clear = ($urandom_range(0, 31) == 0);
      predict();
      if (!m_stall && $urandom_range(0, 1) == 1) begin
        iss_fire  = 1'b1;
        iss_long  = 1'($urandom_range(0, 1));
        iss_waddr = 5'($urandom_range(0, 7));
      end
    end

    next_cycle(); clear_inputs();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
